// File: rtl/solenoid_pkg.sv
// Shared definitions for the solenoid burst sequencer: register offsets,
// CTRL/STATUS bit positions and the sequencer state type.
package solenoid_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_PULSE  = 5'h04;
  localparam logic [4:0] OFF_GAP    = 5'h08;
  localparam logic [4:0] OFF_COUNT  = 5'h0C;
  localparam logic [4:0] OFF_COOL   = 5'h10;
  localparam logic [4:0] OFF_STATUS = 5'h14;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_COOLING   = 1;
  localparam int unsigned ST_REJECTED  = 2;
  localparam int unsigned ST_ARM       = 3;
  localparam int unsigned ST_SHOTS_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    COOL
  } fire_state_t;

endpackage

// File: rtl/fire_timer.sv
// Loadable down-counter shared by all timed sequencer states; holds at 1
// and reports expiry on 1 (or when loaded with 0).
module fire_timer #(
  parameter int unsigned W = 24
) (
  input  logic         PCLK,
  input  logic         PRESERN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value > W'(1)) begin
      value <= value - W'(1);
    end
  end

  assign expire = (value <= W'(1));

endmodule

// File: rtl/solenoid_fire_ctrl.sv
// APB3 solenoid burst sequencer: N pulses separated by gaps, then cooldown.
// Optional hardware interlock enabled by defining SOLENOID_INTERLOCK_EN.
module solenoid_fire_ctrl
  import solenoid_pkg::*;
#(
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned SHOT_W = 8,
  parameter logic [7:0]  BASE   = 8'h20
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        solenoid_out,
  output logic        done_irq
`ifdef SOLENOID_INTERLOCK_EN
  ,
  input  logic        arm
`endif
);

  fire_state_t       state, state_n;
  logic [CNT_W-1:0]  pulse_r, gap_r, cool_r;
  logic [CNT_W-1:0]  w_pulse, w_gap, w_cool, gap_eff;
  logic [CNT_W-1:0]  t_val, t_value;
  logic [SHOT_W-1:0] count_r, shots_left;
  logic [4:0]        off;
  logic [31:0]       status, rdata;
  logic hit, wr, wr_ctrl, start_req, abort_req, arm_ok, rejected;
  logic t_load, t_expire, start_ok, reject, shot_dec, shots_clr, done_c;
  logic unused_bits;

  assign hit       = (PADDR[7:5] == BASE[7:5]);
  assign off       = PADDR[4:0];
  assign wr        = PSEL & PENABLE & PWRITE & hit;
  assign wr_ctrl   = wr & (off == OFF_CTRL);
`ifdef SOLENOID_INTERLOCK_EN
  assign arm_ok    = arm;
`else
  assign arm_ok    = 1'b1;
`endif
  // A low interlock is treated exactly like a firmware ABORT
  assign abort_req = (wr_ctrl & PWDATA[CTRL_ABORT]) | ~arm_ok;
  assign start_req = wr_ctrl & PWDATA[CTRL_START] & ~PWDATA[CTRL_ABORT];
  assign gap_eff   = (w_gap == '0) ? CNT_W'(1) : w_gap;

  always_comb begin
    state_n   = state;
    t_load    = 1'b0;
    t_val     = w_pulse;
    start_ok  = 1'b0;
    reject    = 1'b0;
    shot_dec  = 1'b0;
    shots_clr = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          if (pulse_r == '0 || count_r == '0 || !arm_ok) begin
            reject = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_n  = PULSE;
            t_load   = 1'b1;
            t_val    = pulse_r;
          end
        end
      end
      PULSE, GAP: begin
        if (abort_req ||
            (state == PULSE && t_expire && shots_left == SHOT_W'(1))) begin
          done_c    = 1'b1;
          shots_clr = 1'b1;
          t_load    = 1'b1;
          t_val     = w_cool;
          state_n   = (w_cool == '0) ? IDLE : COOL;
        end else if (t_expire) begin
          t_load = 1'b1;
          if (state == PULSE) begin
            shot_dec = 1'b1;
            state_n  = GAP;
            t_val    = gap_eff;
          end else begin
            state_n  = PULSE;
            t_val    = w_pulse;
          end
        end
      end
      COOL: begin
        if (t_expire) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (start_req && state != IDLE) reject = 1'b1;
  end

  fire_timer #(.W(CNT_W)) u_timer (
    .PCLK     (PCLK),
    .PRESERN  (PRESERN),
    .load     (t_load),
    .load_val (t_val),
    .value    (t_value),
    .expire   (t_expire)
  );

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state        <= IDLE;
      solenoid_out <= 1'b0;
      w_pulse      <= '0;
      w_gap        <= '0;
      w_cool       <= '0;
      shots_left   <= '0;
    end else begin
      state        <= state_n;
      solenoid_out <= (state_n == PULSE);
      if (start_ok) begin
        w_pulse    <= pulse_r;
        w_gap      <= gap_r;
        w_cool     <= cool_r;
        shots_left <= count_r;
      end else if (shots_clr) begin
        shots_left <= '0;
      end else if (shot_dec) begin
        shots_left <= shots_left - SHOT_W'(1);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      pulse_r  <= '0;
      gap_r    <= '0;
      count_r  <= '0;
      cool_r   <= '0;
      rejected <= 1'b0;
    end else begin
      if (wr && off == OFF_PULSE) pulse_r <= PWDATA[CNT_W-1:0];
      if (wr && off == OFF_GAP)   gap_r   <= PWDATA[CNT_W-1:0];
      if (wr && off == OFF_COUNT) count_r <= PWDATA[SHOT_W-1:0];
      if (wr && off == OFF_COOL)  cool_r  <= PWDATA[CNT_W-1:0];
      if (reject) begin
        rejected <= 1'b1;
      end else if (wr && off == OFF_STATUS && PWDATA[ST_REJECTED]) begin
        rejected <= 1'b0;
      end
    end
  end

  always_comb begin
    status                       = '0;
    status[ST_BUSY]              = (state != IDLE);
    status[ST_COOLING]           = (state == COOL);
    status[ST_REJECTED]          = rejected;
`ifdef SOLENOID_INTERLOCK_EN
    status[ST_ARM]               = arm;
`endif
    status[ST_SHOTS_LSB +: 8]    = 8'(shots_left);
  end

  always_comb begin
    rdata = '0;
    if (PSEL && !PWRITE && hit) begin
      case (off)
        OFF_PULSE:  rdata = 32'(pulse_r);
        OFF_GAP:    rdata = 32'(gap_r);
        OFF_COUNT:  rdata = 32'(count_r);
        OFF_COOL:   rdata = 32'(cool_r);
        OFF_STATUS: rdata = status;
        default:    rdata = '0;
      endcase
    end
  end

  assign PRDATA      = rdata;
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign done_irq    = done_c;
  assign unused_bits = ^{PADDR[31:8], PWDATA, t_value};

endmodule

// File: tb/tb_solenoid_fire_ctrl.sv
// Directed bench for solenoid_fire_ctrl; a cycle-schedule model predicts
// solenoid_out/done_irq/STATUS from the burst start cycle and timing values.
module tb_solenoid_fire_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, solenoid_out, done_irq;
`ifdef SOLENOID_INTERLOCK_EN
  logic        arm = 1'b1;
`endif

  solenoid_fire_ctrl #(.CNT_W(24), .SHOT_W(8), .BASE(8'h20)) dut (
    .PCLK         (PCLK),
    .PRESERN      (PRESERN),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .solenoid_out (solenoid_out),
    .done_irq     (done_irq)
`ifdef SOLENOID_INTERLOCK_EN
    ,
    .arm          (arm)
`endif
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int total = 0, passed = 0;
  bit cmp_on = 1'b0;

  // Model: config registers plus the schedule of the current/last burst
  logic [31:0] m_pulse, m_gap, m_count, m_cool;
  bit m_act, m_rej;
  int m_T, m_P, m_G, m_N, m_C, m_E;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic void model_reset();
    m_pulse = '0; m_gap = '0; m_count = '0; m_cool = '0;
    m_act = 1'b0; m_rej = 1'b0;
    m_T = 0; m_P = 0; m_G = 0; m_N = 0; m_C = 0; m_E = 0;
  endfunction

  function automatic int per();
    return m_P + ((m_G == 0) ? 1 : m_G);
  endfunction

  function automatic bit running(int c);
    return m_act && c > m_T && c <= m_E;
  endfunction

  function automatic bit idle(int c);
    return !m_act || c > m_E + m_C;
  endfunction

  function automatic bit exp_out(int c);
    if (!running(c)) return 1'b0;
    return ((c - m_T - 1) % per()) < m_P;
  endfunction

  function automatic bit exp_done(int c);
    return m_act && c == m_E;
  endfunction

  function automatic logic [31:0] exp_status(int c);
    logic [31:0] s;
    int d, comp, rem;
    s = '0;
    s[0] = m_act && c > m_T && c <= m_E + m_C;
    s[1] = m_act && c > m_E && c <= m_E + m_C;
    s[2] = m_rej;
`ifdef SOLENOID_INTERLOCK_EN
    s[3] = arm;
`endif
    rem = 0;
    if (running(c)) begin
      d = c - m_T - m_P;
      comp = (d <= 0) ? 0 : (d + per() - 1) / per();
      if (comp > m_N) comp = m_N;
      rem = m_N - comp;
    end
    s[15:8] = 8'(rem);
    return s;
  endfunction

  function automatic logic [31:0] exp_read(int c, logic [31:0] a);
    if (a[7:5] != 3'b001) return '0;
    case (a[4:0])
      5'h04:   return m_pulse;
      5'h08:   return m_gap;
      5'h0C:   return m_count;
      5'h10:   return m_cool;
      5'h14:   return exp_status(c);
      default: return '0;
    endcase
  endfunction

  function automatic void model_abort(int c);
    if (running(c)) m_E = c;
  endfunction

  function automatic void model_write(int c, logic [31:0] a, logic [31:0] d);
    bit armed;
    armed = 1'b1;
`ifdef SOLENOID_INTERLOCK_EN
    armed = arm;
`endif
    if (a[7:5] != 3'b001) return;
    case (a[4:0])
      5'h04: m_pulse = d & 32'h00FF_FFFF;
      5'h08: m_gap   = d & 32'h00FF_FFFF;
      5'h0C: m_count = d & 32'h0000_00FF;
      5'h10: m_cool  = d & 32'h00FF_FFFF;
      5'h14: if (d[2]) m_rej = 1'b0;
      5'h00: begin
        if (d[1]) model_abort(c);
        else if (d[0]) begin
          if (idle(c) && m_pulse != 0 && m_count != 0 && armed) begin
            m_act = 1'b1; m_T = c;
            m_P = int'(m_pulse); m_G = int'(m_gap);
            m_N = int'(m_count); m_C = int'(m_cool);
            m_E = m_T + (m_N - 1) * per() + m_P;
          end else begin
            m_rej = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endfunction

  always @(negedge PCLK) begin
    if (cmp_on) begin
      check("solenoid_out", 32'(solenoid_out), 32'(exp_out(cyc)));
      check("done_irq", 32'(done_irq), 32'(exp_done(cyc)));
    end
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output int acc);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    acc = cyc;
    model_write(cyc, a, d);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, input string name, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    d = PRDATA;
    check(name, PRDATA, exp_read(cyc, a));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_to(input int n);
    if (cyc > n) check("schedule", 32'(cyc), 32'(n));
    while (cyc < n) begin
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, t3, t4, dummy;
    logic [31:0] rd;
    model_reset();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_out", 32'(solenoid_out), 32'h0);
    check("reset_done", 32'(done_irq), 32'h0);
    check("reset_prdata", PRDATA, 32'h0);
    PRESERN = 1'b1;
    cmp_on  = 1'b1;

    for (int a = 0; a <= 24; a += 4) apb_read(32'h20 + 32'(a), "reset_reg", rd);

    // Burst 1: PULSE=5 GAP=3 COUNT=3 COOLDOWN=10
    apb_write(32'h24, 5, dummy);
    apb_write(32'h28, 3, dummy);
    apb_write(32'h2C, 3, dummy);
    apb_write(32'h30, 10, dummy);
    apb_write(32'h44, 7, dummy);
    apb_read(32'h24, "pulse_rb", rd);
    check("pulse_lit", rd, 32'd5);
    apb_read(32'h2C, "count_rb", rd);
    check("count_lit", rd, 32'd3);
    apb_read(32'h30, "cool_rb", rd);
    check("cool_lit", rd, 32'd10);
    apb_write(32'h20, 1, t);
    check("model_burst_end", 32'(m_E - t), 32'd21);
    wait_to(t + 5);
    apb_read(32'h34, "status_gap", rd);
    check("status_gap_lit", rd, 32'h0000_0201);
    wait_to(t + 21);
    @(negedge PCLK);
    check("last_pulse_out_lit", 32'(solenoid_out), 32'h1);
    check("done_lit", 32'(done_irq), 32'h1);
    wait_to(t + 22);
    @(negedge PCLK);
    check("cool_out_lit", 32'(solenoid_out), 32'h0);
    wait_to(t + 23);
    apb_write(32'h20, 1, dummy);
    wait_to(t + 29);
    apb_read(32'h34, "status_cool_end", rd);
    check("status_cool_end_lit", rd, 32'h0000_0007);
    apb_write(32'h34, 4, dummy);
    apb_read(32'h34, "status_cleared", rd);
    check("status_cleared_lit", rd, 32'h0);

    // Burst 2: PULSE=4 GAP=0 COUNT=2 COOLDOWN=10
    apb_write(32'h24, 4, dummy);
    apb_write(32'h28, 0, dummy);
    apb_write(32'h2C, 2, dummy);
    apb_write(32'h20, 1, t2);
    check("model_gap0_end", 32'(m_E - t2), 32'd9);
    wait_to(t2 + 5);
    @(negedge PCLK);
    check("gap0_low_lit", 32'(solenoid_out), 32'h0);

    // Burst 3 on the first IDLE cycle after cooldown, aborted mid second pulse
    wait_to(t2 + 18);
    apb_write(32'h20, 1, t3);
    check("first_idle_start_cycle", 32'(t3 - t2), 32'd20);
    @(negedge PCLK);
    check("first_idle_start_lit", 32'(solenoid_out), 32'h1);
    wait_to(t3 + 5);
    apb_write(32'h20, 2, dummy);
    @(negedge PCLK);
    check("abort_out_lit", 32'(solenoid_out), 32'h0);
    apb_read(32'h34, "status_abort", rd);
    check("status_abort_lit", rd, 32'h0000_0003);
    wait_to(t3 + 18);
    apb_write(32'h20, 3, dummy);
    apb_write(32'h20, 2, dummy);
    apb_read(32'h34, "status_start_abort", rd);
    check("status_start_abort_lit", rd, 32'h0);

    // Zero PULSE / zero COUNT rejections
    apb_write(32'h24, 0, dummy);
    apb_write(32'h20, 1, dummy);
    apb_read(32'h34, "status_pulse0", rd);
    check("status_pulse0_lit", rd, 32'h0000_0004);
    apb_write(32'h34, 4, dummy);
    apb_write(32'h24, 3, dummy);
    apb_write(32'h2C, 0, dummy);
    apb_write(32'h20, 1, dummy);
    apb_read(32'h34, "status_count0", rd);
    check("status_count0_lit", rd, 32'h0000_0004);
    apb_write(32'h34, 4, dummy);

`ifdef SOLENOID_INTERLOCK_EN
    apb_write(32'h28, 2, dummy);
    apb_write(32'h2C, 3, dummy);
    apb_write(32'h30, 4, dummy);
    arm = 1'b0;
    apb_write(32'h20, 1, dummy);
    apb_read(32'h34, "status_disarmed", rd);
    check("status_disarmed_lit", rd, 32'h0000_0004);
    arm = 1'b1;
    apb_write(32'h34, 4, dummy);
    apb_write(32'h20, 1, t4);
    wait_to(t4 + 6);
    arm = 1'b0;
    model_abort(cyc);
    @(posedge PCLK); #1;
    check("arm_drop_out_lit", 32'(solenoid_out), 32'h0);
    wait_to(t4 + 12);
    arm = 1'b1;
`endif

    // Reset in the middle of a pulse
    apb_write(32'h24, 6, dummy);
    apb_write(32'h28, 1, dummy);
    apb_write(32'h2C, 2, dummy);
    apb_write(32'h30, 5, dummy);
    apb_write(32'h20, 1, t4);
    wait_to(t4 + 3);
    check("pre_reset_out_lit", 32'(solenoid_out), 32'h1);
    #2;
    PRESERN = 1'b0;
    model_reset();
    #1;
    check("async_reset_out_lit", 32'(solenoid_out), 32'h0);
    repeat (2) @(negedge PCLK);
    PRESERN = 1'b1;
    for (int a = 0; a <= 20; a += 4) apb_read(32'h20 + 32'(a), "post_reset_reg", rd);
    apb_read(32'h24, "post_reset_pulse", rd);
    check("post_reset_pulse_lit", rd, 32'h0);
    apb_write(32'h20, 1, dummy);
    repeat (4) @(posedge PCLK);
    #1;

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
